div_32: RTL

DIV_32 -- requirements
Module: div_32

---
 rtl/div_32.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/div_32.sv
// 32-bit unsigned restoring divider: one quotient bit per clock, 32 RUN cycles.
// A zero divisor skips RUN and reports Q=all-ones, R=A with div_zero set.
//
// state  | meaning
// S_IDLE | waiting for start; Q/R/div_zero hold the last result
// S_RUN  | 32 restoring steps, MSB of the dividend first
// S_DONE | one-cycle done pulse, Q/R valid
module div_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Q,
  output logic [31:0] R,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic        dz_q, dz_d;

  logic [32:0] rem_shift;
  logic [31:0] rem_sub;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic        rem_ge;

  // The shifted remainder needs 33 bits for the compare, but after a step it is
  // always below the divisor, so the stored remainder fits in 32 bits.
  // Quotient bits shift into the vacated low end of the dividend register.
  assign rem_shift = {rem_q, dvd_q[31]};
  assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
  assign rem_sub   = rem_shift[31:0] - dvs_q;
  assign rem_step  = rem_ge ? rem_sub : rem_shift[31:0];
  assign quo_step  = {dvd_q[30:0], rem_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (B != 32'd0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  always_comb begin
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    q_d   = q_q;
    r_d   = r_q;
    dz_d  = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (B != 32'd0) begin
            dvd_d = A;
            dvs_d = B;
            rem_d = 32'd0;
            cnt_d = 5'd0;
            dz_d  = 1'b0;
          end else begin
            q_d  = 32'hFFFF_FFFF;
            r_d  = A;
            dz_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        dvd_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          q_d = quo_step;
          r_d = rem_step;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 5'd0;
      dvd_q <= 32'd0;
      dvs_q <= 32'd0;
      rem_q <= 32'd0;
      q_q   <= 32'd0;
      r_q   <= 32'd0;
      dz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      q_q   <= q_d;
      r_q   <= r_d;
      dz_q  <= dz_d;
    end
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign div_zero = dz_q;

endmodule
